// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: loop sequencer for the matrix compute core.
// Walks i<M, j<N, k<K and issues one operand beat per k step. After the last
// beat of each (i,j) it waits for the MAC result, then issues one C write.
// All flat indices come from running adders; there are no multipliers.
module matmul_seq_ctrl #(
    parameter int DIM_W   = 16,
    parameter int IDX_W   = 32,
    parameter int MAC_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      cfg_m,
    input  logic [31:0]      cfg_k,
    input  logic [31:0]      cfg_n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [IDX_W-1:0] op_a_idx,
    output logic [IDX_W-1:0] op_b_idx,
    output logic             op_first,
    output logic             op_last,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [IDX_W-1:0] wr_idx
);

    localparam int CNT_W = (MAC_LAT < 2) ? 2 : $clog2(MAC_LAT + 1) + 1;

    typedef enum logic [2:0] {IDLE, CALC, DRAIN, WRITE, FIN} state_t;

    state_t           state, state_nxt;
    logic [DIM_W-1:0] m_r, k_r, n_r;
    logic [DIM_W-1:0] i_cnt, j_cnt, k_cnt;
    logic [IDX_W-1:0] a_row_base;
    logic [CNT_W-1:0] drain_cnt;

    logic cfg_bad, op_hs, wr_hs, k_end, j_end, i_end;

    // A zero dimension or one that does not fit DIM_W cannot be run.
    assign cfg_bad = (cfg_m == 32'd0) || (cfg_k == 32'd0) || (cfg_n == 32'd0) ||
                     ((cfg_m >> DIM_W) != 32'd0) || ((cfg_k >> DIM_W) != 32'd0) ||
                     ((cfg_n >> DIM_W) != 32'd0);

    assign op_hs = op_valid && op_ready;
    assign wr_hs = wr_valid && wr_ready;
    assign k_end = (k_cnt == k_r - DIM_W'(1));
    assign j_end = (j_cnt == n_r - DIM_W'(1));
    assign i_end = (i_cnt == m_r - DIM_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and the state-decoded strobes.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        op_valid  = 1'b0;
        wr_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = cfg_bad ? FIN : CALC;
            end
            CALC: begin
                busy     = 1'b1;
                op_valid = 1'b1;
                // With a one-cycle MAC the write follows the last beat directly.
                if (op_hs && k_end) state_nxt = (MAC_LAT <= 1) ? WRITE : DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Counter holds MAC_LAT on entry; leaving at 2 lands WRITE
                // exactly MAC_LAT cycles after the last-beat handshake.
                if (drain_cnt <= CNT_W'(2)) state_nxt = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                wr_valid = 1'b1;
                if (wr_hs) state_nxt = (i_end && j_end) ? FIN : CALC;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Loop counters, running index adders and the sticky config error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r        <= '0;
            k_r        <= '0;
            n_r        <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            k_cnt      <= '0;
            a_row_base <= '0;
            drain_cnt  <= '0;
            err        <= 1'b0;
            op_a_idx   <= '0;
            op_b_idx   <= '0;
            op_first   <= 1'b0;
            op_last    <= 1'b0;
            wr_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_r        <= cfg_m[DIM_W-1:0];
                        k_r        <= cfg_k[DIM_W-1:0];
                        n_r        <= cfg_n[DIM_W-1:0];
                        err        <= cfg_bad;
                        i_cnt      <= '0;
                        j_cnt      <= '0;
                        k_cnt      <= '0;
                        a_row_base <= '0;
                        op_a_idx   <= '0;
                        op_b_idx   <= '0;
                        op_first   <= 1'b1;
                        op_last    <= (cfg_k[DIM_W-1:0] == DIM_W'(1));
                        wr_idx     <= '0;
                    end
                end
                CALC: begin
                    if (op_hs) begin
                        if (k_end) begin
                            k_cnt     <= '0;
                            drain_cnt <= CNT_W'(MAC_LAT);
                        end else begin
                            k_cnt    <= k_cnt + DIM_W'(1);
                            op_a_idx <= op_a_idx + IDX_W'(1);
                            op_b_idx <= op_b_idx + IDX_W'(n_r);
                            op_first <= 1'b0;
                            // k+1 is the final step when k+2 == K; k <= K-2 here so no wrap.
                            op_last  <= (k_cnt + DIM_W'(2) == k_r);
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - CNT_W'(1);
                end
                WRITE: begin
                    if (wr_hs) begin
                        wr_idx   <= wr_idx + IDX_W'(1);
                        op_first <= 1'b1;
                        op_last  <= (k_r == DIM_W'(1));
                        if (!j_end) begin
                            j_cnt    <= j_cnt + DIM_W'(1);
                            op_a_idx <= a_row_base;
                            op_b_idx <= IDX_W'(j_cnt) + IDX_W'(1);
                        end else if (!i_end) begin
                            j_cnt      <= '0;
                            i_cnt      <= i_cnt + DIM_W'(1);
                            a_row_base <= a_row_base + IDX_W'(k_r);
                            op_a_idx   <= a_row_base + IDX_W'(k_r);
                            op_b_idx   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: checks beat/write sequences against a
// loop model, latencies, stall stability, error launches and reset abort.
module tb_matmul_seq_ctrl;

    localparam int MAC_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg_m = '0, cfg_k = '0, cfg_n = '0;
    logic        busy, done, err, op_valid, op_first, op_last, wr_valid;
    logic        op_ready = 1'b1, wr_ready = 1'b1;
    logic [31:0] op_a_idx, op_b_idx, wr_idx;

    matmul_seq_ctrl #(.DIM_W(16), .IDX_W(32), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .busy(busy), .done(done), .err(err),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a_idx(op_a_idx), .op_b_idx(op_b_idx),
        .op_first(op_first), .op_last(op_last),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    bit stall = 1'b0;

    logic [31:0] qa[$], qb[$], qw[$];
    bit          qf[$], ql[$];
    int  done_cnt = 0, last_hs_cyc = -100, first_wr_cyc = -1;
    int  start_cyc = 0, done_cyc = 0, wr_hs_cyc = 0;
    bit  stalled_op = 0, stalled_wr = 0, prev_wr = 0, pending = 0;
    logic [31:0] pa, pb, pw;
    bit  pf, pl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observe both buses away from the clock edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_op = 0; stalled_wr = 0; prev_wr = 0; pending = 0;
        end else begin
            chk("bus_excl", op_valid && wr_valid, 0);
            if (stalled_op) begin
                chk("stall_v", op_valid, 1);
                chk("stall_a", op_a_idx, pa);
                chk("stall_b", op_b_idx, pb);
                chk("stall_f", op_first, pf);
                chk("stall_l", op_last, pl);
            end
            if (stalled_wr) begin
                chk("stall_wv", wr_valid, 1);
                chk("stall_w", wr_idx, pw);
            end
            if (wr_valid && !prev_wr) begin
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                chk("wr_lat", cyc - last_hs_cyc, MAC_LAT);
            end
            if (op_valid && op_ready) begin
                chk("order", pending, 0);
                qa.push_back(op_a_idx); qb.push_back(op_b_idx);
                qf.push_back(op_first); ql.push_back(op_last);
                if (op_last) begin last_hs_cyc = cyc; pending = 1; end
            end
            if (wr_valid && wr_ready) begin
                qw.push_back(wr_idx); wr_hs_cyc = cyc; pending = 0;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            stalled_op = op_valid && !op_ready;
            stalled_wr = wr_valid && !wr_ready;
            pa = op_a_idx; pb = op_b_idx; pf = op_first; pl = op_last; pw = wr_idx;
            prev_wr = wr_valid;
        end
    end

    task automatic step();
        @(posedge clk); #1;
        if (stall) begin
            op_ready = 1'($urandom_range(0, 1));
            wr_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic clear_log();
        qa.delete(); qb.delete(); qf.delete(); ql.delete(); qw.delete();
        done_cnt = 0; first_wr_cyc = -1;
    endtask

    task automatic verify(input int m, input int k, input int n);
        int idx = 0;
        chk("n_beats", qa.size(), m * k * n);
        chk("n_wr", qw.size(), m * n);
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++)
                for (int kk = 0; kk < k; kk++) begin
                    if (idx < qa.size()) begin
                        chk("a_idx", qa[idx], i * k + kk);
                        chk("b_idx", qb[idx], kk * n + j);
                        chk("first", qf[idx], kk == 0);
                        chk("last", ql[idx], kk == k - 1);
                    end
                    idx++;
                end
        for (int w = 0; w < qw.size() && w < m * n; w++) chk("wr_idx", qw[w], w);
    endtask

    task automatic run_job(input int m, input int k, input int n, input bit stl, input bit mid);
        bit inj_c = 0, inj_w = 0;
        int t = 0;
        clear_log();
        stall = stl;
        cfg_m = m; cfg_k = k; cfg_n = n;
        start = 1; start_cyc = cyc;
        step();
        start = 0;
        chk("busy_start", busy, 1);
        chk("err_clr", err, 0);
        while (done_cnt == 0 && t < 3000) begin
            if (mid && !inj_c && op_valid && qa.size() >= 2) begin
                start = 1; cfg_m = 5; inj_c = 1;
            end else if (mid && !inj_w && wr_valid) begin
                start = 1; cfg_n = 9; inj_w = 1;
            end
            step();
            start = 0;
            t++;
        end
        chk("timeout", done_cnt != 0, 1);
        stall = 0; op_ready = 1; wr_ready = 1;
        repeat (2) step();
        chk("done_1cyc", done_cnt, 1);
        chk("err_end", err, 0);
        chk("busy_end", busy, 0);
        verify(m, k, n);
    endtask

    task automatic err_job(input logic [31:0] m, input logic [31:0] k, input logic [31:0] n);
        clear_log();
        cfg_m = m; cfg_k = k; cfg_n = n;
        start = 1;
        step();
        start = 0;
        chk("e_done", done, 1);
        chk("e_err", err, 1);
        chk("e_busy", busy, 0);
        chk("e_opv", op_valid, 0);
        step();
        chk("e_done_low", done, 0);
        chk("e_sticky", err, 1);
        repeat (2) step();
        chk("e_traffic", qa.size() + qw.size(), 0);
        chk("e_done_cnt", done_cnt, 1);
    endtask

    initial begin
        int t;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_opv", op_valid, 0);
        chk("rst_wrv", wr_valid, 0);
        chk("rst_a", op_a_idx, 0);
        chk("rst_w", wr_idx, 0);
        rst_n = 1;
        step();

        run_job(2, 3, 2, 0, 0);

        run_job(1, 1, 1, 0, 0);
        chk("t111_wr", first_wr_cyc - start_cyc, MAC_LAT + 1);
        chk("t111_done", done_cyc - wr_hs_cyc, 1);

        err_job(32'd2, 32'd0, 32'd2);
        err_job(32'h0001_0000, 32'd1, 32'd1);

        run_job(3, 4, 2, 1, 0);
        run_job(2, 3, 2, 0, 1);

        // Abort a run while it waits out MAC latency.
        clear_log();
        cfg_m = 2; cfg_k = 2; cfg_n = 2;
        start = 1;
        step();
        start = 0;
        t = 0;
        while (!(busy && !op_valid && !wr_valid) && t < 200) begin step(); t++; end
        chk("drain_seen", busy && !op_valid && !wr_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_opv", op_valid, 0);
        chk("ab_wrv", wr_valid, 0);
        chk("ab_done", done, 0);
        chk("ab_a", op_a_idx, 0);
        chk("ab_b", op_b_idx, 0);
        chk("ab_w", wr_idx, 0);
        step();
        rst_n = 1;
        repeat (3) step();
        chk("ab_no_done", done_cnt, 0);
        run_job(1, 2, 2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
